free_list: RTL

- Circular FIFO of free physical-register tags. It is the counterpart to the ROB retire path.
- Dispatch pops the head tag, which becomes T_new_in of the ROB.
- ROB retire pushes the retiring T_old (T_free / T_out_valid) at the tail.
- On branch_not_taken, all speculatively allocated tags are reclaimed in one cycle by moving the head pointer back; no data copying is done.

---
 rtl/free_list_pkg.sv | 21 ++
 rtl/free_list_if.sv | 24 ++
 rtl/free_list_ptr.sv | 27 ++
 rtl/free_list.sv | 84 ++++++++
 4 files changed

// File: rtl/free_list_pkg.sv
// Shared sizes, tag types and constants for the physical-register free list.
package free_list_pkg;

    localparam int FL_SIZE   = 32;
    localparam int PR_SIZE   = 64;
    localparam int ARCH_SIZE = 32;
    localparam int ROB_SIZE  = 32;

    localparam int TAG_W = $clog2(PR_SIZE);
    localparam int PTR_W = $clog2(FL_SIZE);
    localparam int CNT_W = PTR_W + 1;

    // Ready bit on top of the 6-bit physical tag
    typedef logic [TAG_W:0]   PHYS_REG;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] count_t;

    localparam PHYS_REG INVALID_TAG = 7'b1111111;

endpackage

// File: rtl/free_list_if.sv
// Dispatch/retire/flush bundle between the pipeline and the free list.
interface free_list_if
    import free_list_pkg::*;
();
    logic    enable;
    logic    dispatch_en;
    logic    retire_valid;
    PHYS_REG T_free_in;
    logic    branch_not_taken;
    PHYS_REG T_new_out;
    logic    free_valid;
    count_t  free_count;
    logic    fl_empty;

    modport master (
        output enable, dispatch_en, retire_valid, T_free_in, branch_not_taken,
        input  T_new_out, free_valid, free_count, fl_empty
    );

    modport slave (
        input  enable, dispatch_en, retire_valid, T_free_in, branch_not_taken,
        output T_new_out, free_valid, free_count, fl_empty
    );
endinterface

// File: rtl/free_list_ptr.sv
// Wrapping FIFO pointer with increment and a load port; wraps by overflow.
module free_list_ptr
    import free_list_pkg::*;
(
    input  logic clock,
    input  logic reset,
    input  logic inc,
    input  logic load,
    input  ptr_t load_val,
    output ptr_t ptr,
    output ptr_t ptr_inc
);

    assign ptr_inc = ptr + PTR_W'(1);

    // Load wins over increment so a flush can reposition the pointer outright
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr <= '0;
        end else if (load) begin
            ptr <= load_val;
        end else if (inc) begin
            ptr <= ptr_inc;
        end
    end

endmodule

// File: rtl/free_list.sv
// Circular FIFO of free physical-register tags; a mispredict reclaims every
// speculatively dispatched tag by snapping head back to the tail.
module free_list
    import free_list_pkg::*;
(
    input  logic                             clock,
    input  logic                             reset,
    free_list_if.slave                       fl,
    output logic [FL_SIZE-1:0][TAG_W-1:0]    fl_table_out,
    output ptr_t                             head_out,
    output ptr_t                             tail_out
);

    tag_t   entry [FL_SIZE];
    count_t count;
    ptr_t   head, tail, tail_inc, tail_next, head_inc_unused;
    logic   full, empty, do_pop, do_push, do_flush;
    logic   unused_ready_bit;

    assign full     = (count == count_t'(FL_SIZE));
    assign empty    = (count == '0);
    assign do_pop   = fl.enable & fl.dispatch_en & ~empty & ~fl.branch_not_taken;
    assign do_push  = fl.enable & fl.retire_valid & ~full;
    assign do_flush = fl.enable & fl.branch_not_taken;

    // The retire write lands before the flush, so head must skip past it
    assign tail_next = do_push ? tail_inc : tail;

    assign unused_ready_bit = fl.T_free_in[TAG_W];

    free_list_ptr u_head (
        .clock    (clock),
        .reset    (reset),
        .inc      (do_pop),
        .load     (do_flush),
        .load_val (tail_next),
        .ptr      (head),
        .ptr_inc  (head_inc_unused)
    );

    free_list_ptr u_tail (
        .clock    (clock),
        .reset    (reset),
        .inc      (do_push),
        .load     (1'b0),
        .load_val (tail_next),
        .ptr      (tail),
        .ptr_inc  (tail_inc)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FL_SIZE; i++) begin
                entry[i] <= TAG_W'(ARCH_SIZE + i);
            end
        end else if (do_push) begin
            entry[tail] <= fl.T_free_in[TAG_W-1:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || do_flush) begin
            count <= count_t'(FL_SIZE);
        end else begin
            count <= count + count_t'(do_push) - count_t'(do_pop);
        end
    end

    assign fl.T_new_out  = empty ? INVALID_TAG : {1'b0, entry[head]};
    assign fl.free_valid = ~empty;
    assign fl.free_count = count;
    assign fl.fl_empty   = empty;

    always_comb begin
        fl_table_out = '0;
        for (int i = 0; i < FL_SIZE; i++) begin
            fl_table_out[i] = entry[i];
        end
    end

    assign head_out = head;
    assign tail_out = tail;

endmodule
